// File: rtl/hwpe_stream_package.sv
// Shared hwpe-stream types: realigner control word, realign job descriptor
// and the realign sequencer state encoding.
package hwpe_stream_package;

  localparam int unsigned REALIGN_LEN_W = 16;

  typedef struct packed {
    logic                     enable;
    logic                     realign;
    logic                     first;
    logic                     last;
    logic                     last_packet;
    logic [REALIGN_LEN_W-1:0] line_length;
  } ctrl_realign_t;

  // Register-file view of one strided 2D read job.
  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] line_length;
    logic [31:0] line_stride;
    logic [15:0] num_lines;
  } realign_job_t;

  typedef enum logic [1:0] {
    RA_IDLE  = 2'd0,
    RA_ISSUE = 2'd1,
    RA_DONE  = 2'd2
  } realign_state_e;

endpackage

// File: rtl/hwpe_stream_realign_strb_gen.sv
// Per-word byte strobe and first/last flags for a possibly misaligned line.
// Purely combinational so both the coupled and decoupled counters can share it.
module hwpe_stream_realign_strb_gen
  import hwpe_stream_package::*;
#(
  parameter int unsigned BE        = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned OW        = $clog2(BE)
) (
  input  logic [OW-1:0]        offset,
  input  logic                 realign,
  input  logic [CNT_WIDTH-1:0] word_cnt,
  input  logic [CNT_WIDTH:0]   num_words,
  output logic [BE-1:0]        strb,
  output logic                 first,
  output logic                 last
);

  localparam logic [BE-1:0] ONES = '1;

  logic [CNT_WIDTH:0] last_idx;

  assign last_idx = num_words - (CNT_WIDTH+1)'(1);
  assign first    = (word_cnt == '0);
  assign last     = ({1'b0, word_cnt} == last_idx);

  // A misaligned line drops the leading bytes of its first word and keeps
  // only those leading bytes on the extra trailing word.
  always_comb begin
    strb = ONES;
    if (realign) begin
      if (first)     strb = ONES << offset;
      else if (last) strb = ~(ONES << offset);
    end
  end

endmodule

// File: rtl/hwpe_stream_realign_ctrl.sv
// Sequencer for strided, byte-misaligned 2D TCDM reads feeding the source
// realigner: one word-aligned request per handshake with matching ctrl/strobe.
module hwpe_stream_realign_ctrl
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned BE         = DATA_WIDTH/8,
  parameter int unsigned OW         = $clog2(BE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  line_length_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  input  logic [CNT_WIDTH-1:0]  num_lines_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [BE-1:0]         req_strb_o,
  output ctrl_realign_t         ctrl_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE-1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(BE);

  realign_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] line_base_q, addr_q, stride_q;
  logic [CNT_WIDTH-1:0]  word_cnt_q, line_cnt_q, len_q, nlines_q;
  logic [OW-1:0]         off_q;
  logic                  rflag_q;
  logic [BE-1:0]         strb_q;
  logic                  first_q, last_q;

  logic                  start_ok, job_empty, hs, line_last, job_last;
  logic [CNT_WIDTH:0]    num_words_q;
  logic [ADDR_WIDTH-1:0] next_line_base;

  logic [OW-1:0]         gen_off;
  logic                  gen_r;
  logic [CNT_WIDTH-1:0]  gen_cnt;
  logic [CNT_WIDTH:0]    gen_w;
  logic [BE-1:0]         gen_strb;
  logic                  gen_first, gen_last;

  assign start_ok       = (state_q == RA_IDLE) && start_i;
  assign job_empty      = (line_length_i == '0) || (num_lines_i == '0);
  assign hs             = (state_q == RA_ISSUE) && req_ready_i;
  assign num_words_q    = {1'b0, len_q} + {{CNT_WIDTH{1'b0}}, rflag_q};
  assign line_last      = (line_cnt_q == nlines_q - CNT_WIDTH'(1));
  // last_q always describes the word currently on the bus.
  assign job_last       = last_q && line_last;
  assign next_line_base = line_base_q + (stride_q & ALIGN_MASK);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= RA_IDLE;
    else if (clear_i) state_q <= RA_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RA_IDLE:  if (start_i) state_d = job_empty ? RA_DONE : RA_ISSUE;
      RA_ISSUE: if (hs && job_last) state_d = RA_DONE;
      RA_DONE:  state_d = RA_IDLE;
      default:  state_d = RA_IDLE;
    endcase
  end

  always_comb begin
    req_valid_o = (state_q == RA_ISSUE);
    busy_o      = (state_q != RA_IDLE);
    done_o      = (state_q == RA_DONE);
  end

  // ---------------- strobe of the word about to be presented ----------------
  always_comb begin
    gen_off = off_q;
    gen_r   = rflag_q;
    gen_w   = num_words_q;
    gen_cnt = word_cnt_q;
    if (start_ok) begin
      gen_off = base_addr_i[OW-1:0];
      gen_r   = |base_addr_i[OW-1:0];
      gen_w   = {1'b0, line_length_i} + {{CNT_WIDTH{1'b0}}, gen_r};
      gen_cnt = '0;
    end else if (hs) begin
      gen_cnt = last_q ? '0 : word_cnt_q + CNT_WIDTH'(1);
    end
  end

  hwpe_stream_realign_strb_gen #(
    .BE        (BE),
    .CNT_WIDTH (CNT_WIDTH),
    .OW        (OW)
  ) i_strb_gen (
    .offset    (gen_off),
    .realign   (gen_r),
    .word_cnt  (gen_cnt),
    .num_words (gen_w),
    .strb      (gen_strb),
    .first     (gen_first),
    .last      (gen_last)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_base_q <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      len_q       <= '0;
      nlines_q    <= '0;
      off_q       <= '0;
      rflag_q     <= 1'b0;
      strb_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else if (clear_i) begin
      line_base_q <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      len_q       <= '0;
      nlines_q    <= '0;
      off_q       <= '0;
      rflag_q     <= 1'b0;
      strb_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else if (start_ok) begin
      off_q       <= base_addr_i[OW-1:0];
      rflag_q     <= |base_addr_i[OW-1:0];
      len_q       <= line_length_i;
      nlines_q    <= num_lines_i;
      stride_q    <= line_stride_i;
      line_base_q <= base_addr_i & ALIGN_MASK;
      addr_q      <= base_addr_i & ALIGN_MASK;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      if (!job_empty) begin
        strb_q  <= gen_strb;
        first_q <= gen_first;
        last_q  <= gen_last;
      end
    end else if (hs) begin
      if (job_last) begin
        strb_q  <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        if (last_q) begin
          word_cnt_q  <= '0;
          line_cnt_q  <= line_cnt_q + CNT_WIDTH'(1);
          line_base_q <= next_line_base;
          addr_q      <= next_line_base;
        end else begin
          word_cnt_q  <= word_cnt_q + CNT_WIDTH'(1);
          addr_q      <= addr_q + WORD_STEP;
        end
        strb_q  <= gen_strb;
        first_q <= gen_first;
        last_q  <= gen_last;
      end
    end
  end

  assign req_addr_o = addr_q;
  assign req_strb_o = strb_q;

  always_comb begin
    ctrl_o             = '0;
    ctrl_o.enable      = (state_q != RA_IDLE);
    ctrl_o.realign     = rflag_q;
    ctrl_o.first       = first_q;
    ctrl_o.last        = last_q;
    ctrl_o.last_packet = 1'b0;
    ctrl_o.line_length = REALIGN_LEN_W'(len_q);
  end

endmodule

// File: tb/tb_hwpe_stream_realign_ctrl.sv
// Scoreboard bench for the realign sequencer: directed jobs push expected
// requests, a negedge monitor pops and compares every granted word.
module tb_hwpe_stream_realign_ctrl;
  import hwpe_stream_package::*;

  logic          clk = 1'b0;
  logic          rst_n, clear, start, ready;
  logic [31:0]   base, stride;
  logic [15:0]   len, nlines;
  logic          valid, busy, done;
  logic [31:0]   addr;
  logic [3:0]    strb;
  ctrl_realign_t ctrl;

  always #5 clk = ~clk;

  hwpe_stream_realign_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .base_addr_i   (base),
    .line_length_i (len),
    .line_stride_i (stride),
    .num_lines_i   (nlines),
    .req_valid_o   (valid),
    .req_ready_i   (ready),
    .req_addr_o    (addr),
    .req_strb_o    (strb),
    .ctrl_o        (ctrl),
    .busy_o        (busy),
    .done_o        (done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        first;
    logic        last;
    logic        realign;
    logic [15:0] len;
    logic        fin;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] byte_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       chk_idle = 1'b0, empty_armed = 1'b0, collect = 1'b0, final_chk = 1'b0;

  task automatic push_exp(input logic [31:0] a, input logic [3:0] s, input logic f,
                          input logic l, input logic r, input logic [15:0] ln, input logic fin);
    exp_t e;
    e.addr = a; e.strb = s; e.first = f; e.last = l; e.realign = r; e.len = ln; e.fin = fin;
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t          e;
    logic          done_pend, exp_done, held_v;
    logic [31:0]   h_addr;
    logic [3:0]    h_strb;
    ctrl_realign_t h_ctrl;
    logic [7:0]    eb;
    done_pend = 1'b0;
    held_v    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_pend = 1'b0;
        held_v    = 1'b0;
      end else begin
        if (chk_idle) begin
          checks++;
          if ({valid, addr, strb, ctrl, busy, done} !== '0) begin
            errors++;
            $display("FAIL idle_state: valid=%b addr=%h strb=%h ctrl=%h busy=%b done=%b, want all 0",
                     valid, addr, strb, ctrl, busy, done);
          end
        end
        exp_done  = done_pend || empty_armed;
        done_pend = 1'b0;
        if (done || exp_done) begin
          checks++;
          if (done !== exp_done) begin
            errors++;
            $display("FAIL done_pulse: got %b want %b", done, exp_done);
          end
        end
        if (valid) begin
          if (held_v) begin
            checks++;
            if (addr !== h_addr || strb !== h_strb || ctrl !== h_ctrl) begin
              errors++;
              $display("FAIL backpressure_hold: addr=%h strb=%h ctrl=%h, want addr=%h strb=%h ctrl=%h",
                       addr, strb, ctrl, h_addr, h_strb, h_ctrl);
            end
          end
          if (ready) begin
            held_v = 1'b0;
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_req: addr=%h strb=%h, want no request", addr, strb);
            end else begin
              e = sb_q.pop_front();
              if ({addr, strb, ctrl.first, ctrl.last, ctrl.realign, ctrl.line_length, ctrl.enable, ctrl.last_packet, busy}
                  !== {e.addr, e.strb, e.first, e.last, e.realign, e.len, 1'b1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL req_word: addr=%h strb=%h f=%b l=%b r=%b len=%0d en=%b lp=%b busy=%b, want addr=%h strb=%h f=%b l=%b r=%b len=%0d en=1 lp=0 busy=1",
                         addr, strb, ctrl.first, ctrl.last, ctrl.realign, ctrl.line_length, ctrl.enable,
                         ctrl.last_packet, busy, e.addr, e.strb, e.first, e.last, e.realign, e.len);
              end
              if (e.fin) done_pend = 1'b1;
            end
            // Byte memory holds the low address byte at every location.
            if (collect) begin
              for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                  checks++;
                  if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL realign_byte: extra byte %h, want none", addr[7:0] + 8'(b));
                  end else begin
                    eb = byte_q.pop_front();
                    if (addr[7:0] + 8'(b) !== eb) begin
                      errors++;
                      $display("FAIL realign_byte: got %h want %h", addr[7:0] + 8'(b), eb);
                    end
                  end
                end
              end
            end
          end else begin
            held_v = 1'b1;
            h_addr = addr;
            h_strb = strb;
            h_ctrl = ctrl;
          end
        end else begin
          held_v = 1'b0;
        end
        if (final_chk) begin
          checks++;
          if (sb_q.size() != 0 || byte_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words and %0d bytes left, want 0 and 0",
                     sb_q.size(), byte_q.size());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_job(input logic [31:0] b, input logic [15:0] l,
                           input logic [31:0] s, input logic [15:0] n);
    base = b; len = l; stride = s; nlines = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int c = 0; c < maxc && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; ready = 1'b1;
    base = '0; stride = '0; len = '0; nlines = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_idle = 1'b1;
    @(negedge clk); #1 chk_idle = 1'b0;

    // Aligned 3x2 job, with a stray start mid-job that must be ignored.
    push_exp(32'h100, 4'hF, 1, 0, 0, 3, 0);
    push_exp(32'h104, 4'hF, 0, 0, 0, 3, 0);
    push_exp(32'h108, 4'hF, 0, 1, 0, 3, 0);
    push_exp(32'h140, 4'hF, 1, 0, 0, 3, 0);
    push_exp(32'h144, 4'hF, 0, 0, 0, 3, 0);
    push_exp(32'h148, 4'hF, 0, 1, 0, 3, 1);
    start_job(32'h100, 16'd3, 32'h40, 16'd2);
    @(posedge clk); #1;
    base = 32'h999; len = 16'd7; nlines = 16'd9; stride = 32'h4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(50);

    // Misaligned job under backpressure; realigned bytes must be 0x101..0x108.
    for (int i = 1; i <= 8; i++) byte_q.push_back(8'(i));
    collect = 1'b1;
    push_exp(32'h100, 4'hE, 1, 0, 1, 2, 0);
    push_exp(32'h104, 4'hF, 0, 0, 1, 2, 0);
    push_exp(32'h108, 4'h1, 0, 1, 1, 2, 1);
    start_job(32'h101, 16'd2, 32'h40, 16'd1);
    begin
      logic [3:0] pat;
      pat = 4'b1001;
      for (int i = 3; i >= 0; i--) begin
        ready = pat[i];
        @(posedge clk); #1;
      end
    end
    ready = 1'b1;
    drain(50);
    collect = 1'b0;

    // Abort: clear after the second grant of a 6-word job.
    push_exp(32'h200, 4'hF, 1, 0, 0, 3, 0);
    push_exp(32'h204, 4'hF, 0, 0, 0, 3, 0);
    start_job(32'h200, 16'd3, 32'h40, 16'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; ready = 1'b1;
    chk_idle = 1'b1;
    @(negedge clk); #1 chk_idle = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Empty job: no requests, done one cycle after start.
    start_job(32'h0, 16'd0, 32'h0, 16'd5);
    empty_armed = 1'b1;
    @(negedge clk); #1 empty_armed = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Negative stride wrapping below zero, single-word lines.
    push_exp(32'h0000_0004, 4'hF, 1, 1, 0, 1, 0);
    push_exp(32'hFFFF_FFFC, 4'hF, 1, 1, 0, 1, 1);
    start_job(32'h4, 16'd1, 32'hFFFF_FFF8, 16'd2);
    drain(50);

    final_chk = 1'b1;
    @(negedge clk); #1 final_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hwpe_stream_realign_ctrl.md
# hwpe_stream_realign_ctrl

Sequencer that drives `hwpe_stream_source_realign` and its TCDM load port for strided, possibly byte-misaligned 2D reads.
- Takes a job (byte base address, words per line, line stride, line count).
- Issues one word-aligned request per cycle on a valid/ready handshake.
- Drives, in the same cycle as each request, the realigner's `ctrl_realign_t` and per-word byte strobe.
- Sits between the HWPE controller/register file and the source-side streamer datapath; zero-latency (non-decoupled) TCDM.

## Interface
- `DATA_WIDTH`, 32: stream/TCDM word width in bits; BE = DATA_WIDTH/8, OW = $clog2(BE).
- `ADDR_WIDTH`, 32: byte address width.
- `CNT_WIDTH`, 16: width of the word and line counters; matches `ctrl_realign_t.line_length`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous soft clear; same effect as reset.
- `start_i`  in  1  job start pulse; sampled only in IDLE.
- `base_addr_i`  in  ADDR_WIDTH  byte address of the first byte of line 0.
- `line_length_i`  in  CNT_WIDTH  payload words per line, L.
- `line_stride_i`  in  ADDR_WIDTH  byte offset between line bases; two's complement.
- `num_lines_i`  in  CNT_WIDTH  line count, N.
- `req_valid_o`  out  1  TCDM request valid.
- `req_ready_i`  in  1  TCDM grant.
- `req_addr_o`  out  ADDR_WIDTH  word-aligned address; low OW bits are 0.
- `req_strb_o`  out  BE  byte strobe of the current word; also wired to the realigner `strb_i`.
- `ctrl_o`  out  ctrl_realign_t  realigner control.
- `busy_o`  out  1  high outside IDLE.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- Offset o = base_addr_i[OW-1:0], latched at start. Realign flag R = (o != 0).
- Requests per line: W = L + R.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE on start_i when L != 0 and N != 0.
  - IDLE -> DONE on start_i when L == 0 or N == 0; no requests are issued.
  - ISSUE -> DONE on the handshake of the last word of the last line.
  - DONE -> IDLE unconditionally.
- Registers: line_base, word_addr, word_cnt, line_cnt, o, R, L, N, stride.
  - On start: line_base = word_addr = base_addr_i & ~(BE-1); counters = 0.
- On each handshake (req_valid_o & req_ready_i):
  - Mid-line: word_cnt++, word_addr += BE.
  - At word_cnt == W-1: word_cnt = 0, line_cnt++, line_base += stride (aligned), word_addr = new line_base.
- Strobe for the current word:
  - R == 0: '1.
  - word_cnt == 0: '1 << o.
  - word_cnt == W-1: ~('1 << o).
  - Otherwise: '1.
- ctrl_o fields:
  - enable = busy_o.
  - realign = R.
  - first = (word_cnt == 0).
  - last = (word_cnt == W-1).
  - line_length = L.
  - last_packet = 0. It is reserved and held low.
- With L = 1 and R = 0, first and last are both high on the single word.
- A start_i while busy is ignored; the latched job is unchanged.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters do not saturate; the job bounds them.

## Timing
- Reset/clear values: state IDLE, req_valid_o 0, req_addr_o 0, req_strb_o 0, ctrl_o all 0, busy_o 0, done_o 0. clear_i overrides start_i in the same cycle.
- req_valid_o rises the cycle after the accepted start_i and stays high through ISSUE.
- req_addr_o, req_strb_o and ctrl_o are registered. They change only after a handshake and are stable while req_ready_i is low.
- Back-to-back grants give one word per cycle. A full job takes N*W handshake cycles.
- done_o is high in the DONE cycle: the cycle after the final handshake, or the cycle after start for an empty job. busy_o is high in ISSUE and DONE.
- Reset or clear mid-job aborts the job immediately. No further requests are issued and no done_o pulse occurs.

## Structure
- `hwpe_stream_package` holds `ctrl_realign_t` (already shared).
- Add `realign_job_t` to the package: {base_addr, line_length, line_stride, num_lines}, for register-file hookup.
- One sub-module, `hwpe_stream_realign_strb_gen`: combinational (o, R, word_cnt, W) -> strobe, first, last. It is reused by the decoupled-mode counter.

## Test plan
- Aligned job: base 0x100, L=3, N=2, stride 0x40, BE=4.
  - Expect addresses 0x100, 0x104, 0x108, 0x140, 0x144, 0x148; all strb 0xF; realign 0.
  - first on words 0 and 3, last on words 2 and 5; done_o one cycle after the 6th grant.
- Misaligned job: base 0x101, L=2, N=1.
  - Expect 3 requests: 0x100/0xE, 0x104/0xF, 0x108/0x1; realign 1.
  - Chained realigner output equals bytes 0x101..0x108 in order.
- Backpressure: req_ready_i toggling 1,0,0,1 during the misaligned job.
  - Address, strb and ctrl_o hold while ready is low; no word is skipped or duplicated.
- Empty job: L=0, N=5.
  - No req_valid_o; done_o pulses exactly one cycle after start.
- Abort and ignore:
  - clear_i after the 2nd grant of a 6-word job: next cycle all outputs are at reset values and no done_o pulse occurs.
  - A start_i pulsed during ISSUE is ignored.
- Negative stride with wrap: base 0x4, stride -8 (0xFFFFFFF8), L=1, N=2.
  - Expect addresses 0x4, then 0xFFFFFFFC.
